// File: rtl/line_follow_ctrl.sv
// Line-following robot controller: inductive tape sensors, cone/junction markers,
// two-process FSM driving an H-bridge direction code and PWM enables.
module line_follow_ctrl #(
  parameter int NSENS     = 3,
  parameter int PWM_W     = 8,
  parameter int DUTY_FWD  = 200,
  parameter int DUTY_TURN = 140,
  parameter int MIN_SPIN  = 1000,
  parameter int LOST_TO   = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [NSENS-1:0] induct,
  input  logic             proxim,
  input  logic             red,
  output logic [3:0]       motor_in,
  output logic [1:0]       motor_en,
  output logic [2:0]       state,
  output logic             fault,
  output logic [7:0]       jct_cnt
);

  localparam int C       = (NSENS - 1) / 2;
  localparam int TMR_MAX = (MIN_SPIN > LOST_TO) ? MIN_SPIN : LOST_TO;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [3:0] M_FWD   = 4'b1001;
  localparam logic [3:0] M_LEFT  = 4'b0101;
  localparam logic [3:0] M_RIGHT = 4'b1010;
  localparam logic [3:0] M_HALT  = 4'b0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FOLLOW = 3'd1,
    JUNC   = 3'd2,
    SPIN   = 3'd3,
    LOST   = 3'd4,
    FAULT  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [NSENS-1:0]   ind_s1_q, ind_s1_d, ind_s2_q, ind_s2_d, on_q, on_d;
  logic [2:0]         prx_sync_q, prx_sync_d, red_sync_q, red_sync_d;
  logic [1:0]         rdy_q, rdy_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [3:0]         motor_in_q, motor_in_d, last_cmd_q, last_cmd_d;
  logic [1:0]         motor_en_q, motor_en_d;
  logic               fault_q, fault_d, dir_sel_q, dir_sel_d, cone_flag_q, cone_flag_d;
  logic [7:0]         jct_cnt_q, jct_cnt_d;

  logic               prx_rise, red_rise, red_fall;
  logic               pat_jct, pat_none, in_fj, tmr_done, lost_to;
  logic [3:0]         dec_cmd;
  logic [PWM_W:0]     duty;
  int                 n_above, n_below;

  assign prx_rise = prx_sync_q[1] & ~prx_sync_q[2];
  assign red_rise = red_sync_q[1] & ~red_sync_q[2];
  assign red_fall = ~red_sync_q[1] & red_sync_q[2];

  // Sensor pattern decode on the registered on-tape vector
  always_comb begin
    n_above  = 0;
    n_below  = 0;
    for (int i = 0; i < NSENS; i++) begin
      if (on_q[i]) begin
        if (i > C)      n_above = n_above + 1;
        else if (i < C) n_below = n_below + 1;
      end
    end
    pat_jct  = &on_q;
    pat_none = ~|on_q;
    if (n_above > n_below)      dec_cmd = M_LEFT;
    else if (n_above < n_below) dec_cmd = M_RIGHT;
    else                        dec_cmd = M_FWD;
  end

  always_comb begin
    ind_s1_d    = induct;
    ind_s2_d    = ind_s1_q;
    on_d        = ~ind_s2_q;
    prx_sync_d  = {prx_sync_q[1:0], proxim};
    red_sync_d  = {red_sync_q[1:0], red};
    rdy_d       = {rdy_q[0], 1'b1};
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    state_d     = state_q;
    jct_cnt_d   = jct_cnt_q;
    dir_sel_d   = dir_sel_q;
    cone_flag_d = cone_flag_q;
    last_cmd_d  = last_cmd_q;
    in_fj       = (state_q == FOLLOW) || (state_q == JUNC);
    tmr_done    = tmr_q >= TMR_W'(MIN_SPIN - 1);
    lost_to     = tmr_q >= TMR_W'(LOST_TO - 1);

    // No transitions until the released reset has been seen on two edges
    if (rdy_q[1]) begin
      if (!run) begin
        state_d = IDLE;
      end else begin
        if (red_rise) begin
          jct_cnt_d = jct_cnt_q + 8'd1;
          dir_sel_d = ~dir_sel_q;
        end
        if (red_fall) cone_flag_d = 1'b0;
        if ((state_q == LOST) && lost_to) begin
          state_d = FAULT;
        end else if (prx_rise && in_fj) begin
          state_d     = SPIN;
          cone_flag_d = ~cone_flag_q;
        end else if (red_rise && cone_flag_q && in_fj) begin
          state_d = SPIN;
        end else begin
          case (state_q)
            IDLE:    state_d = FOLLOW;
            FOLLOW:  if (pat_jct) state_d = JUNC; else if (pat_none) state_d = LOST;
            JUNC:    if (tmr_done && on_q[C] && !pat_jct) state_d = FOLLOW;
            SPIN:    if (tmr_done && on_q[C]) state_d = FOLLOW;
            LOST:    if (!pat_none) state_d = FOLLOW;
            default: state_d = state_q;
          endcase
        end
      end
    end

    // Turn/lost timer restarts on every state entry and saturates
    tmr_d = tmr_q;
    if (state_d != state_q) tmr_d = '0;
    else if (((state_q == JUNC) || (state_q == SPIN) || (state_q == LOST)) &&
             (tmr_q != TMR_W'(TMR_MAX)))
      tmr_d = tmr_q + 1'b1;

    case (state_d)
      FOLLOW: begin
        if (pat_jct || pat_none) begin
          motor_in_d = last_cmd_q;
        end else begin
          motor_in_d = dec_cmd;
          last_cmd_d = dec_cmd;
        end
      end
      JUNC:    motor_in_d = dir_sel_d ? M_LEFT : M_RIGHT;
      SPIN:    motor_in_d = M_RIGHT;
      LOST:    motor_in_d = last_cmd_q;
      default: motor_in_d = M_HALT;
    endcase

    case (motor_in_d)
      M_FWD:           duty = (PWM_W+1)'(DUTY_FWD);
      M_LEFT, M_RIGHT: duty = (PWM_W+1)'(DUTY_TURN);
      default:         duty = '0;
    endcase
    motor_en_d = ({1'b0, pwm_cnt_q} < duty) ? 2'b11 : 2'b00;
    fault_d    = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ind_s1_q    <= '0;
      ind_s2_q    <= '0;
      on_q        <= '0;
      prx_sync_q  <= '0;
      red_sync_q  <= '0;
      rdy_q       <= '0;
      pwm_cnt_q   <= '0;
      tmr_q       <= '0;
      state_q     <= IDLE;
      motor_in_q  <= M_HALT;
      motor_en_q  <= 2'b00;
      fault_q     <= 1'b0;
      jct_cnt_q   <= 8'd0;
      dir_sel_q   <= 1'b0;
      cone_flag_q <= 1'b0;
      last_cmd_q  <= M_FWD;
    end else begin
      ind_s1_q    <= ind_s1_d;
      ind_s2_q    <= ind_s2_d;
      on_q        <= on_d;
      prx_sync_q  <= prx_sync_d;
      red_sync_q  <= red_sync_d;
      rdy_q       <= rdy_d;
      pwm_cnt_q   <= pwm_cnt_d;
      tmr_q       <= tmr_d;
      state_q     <= state_d;
      motor_in_q  <= motor_in_d;
      motor_en_q  <= motor_en_d;
      fault_q     <= fault_d;
      jct_cnt_q   <= jct_cnt_d;
      dir_sel_q   <= dir_sel_d;
      cone_flag_q <= cone_flag_d;
      last_cmd_q  <= last_cmd_d;
    end
  end

  assign motor_in = motor_in_q;
  assign motor_en = motor_en_q;
  assign state    = state_q;
  assign fault    = fault_q;
  assign jct_cnt  = jct_cnt_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl: a 3-sensor and a 5-sensor instance share
// clock, reset and markers; short turn/lost timeouts keep the run brief.
module tb_line_follow_ctrl;

  localparam int MS = 20;
  localparam int LT = 40;

  logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0, proxim = 1'b0, red = 1'b0;
  logic [2:0] induct  = 3'b101;
  logic [4:0] induct5 = 5'b11011;
  logic [3:0] motor_in_a, motor_in_b;
  logic [1:0] motor_en_a, motor_en_b;
  logic [2:0] state_a, state_b;
  logic       fault_a, fault_b;
  logic [7:0] jct_a, jct_b;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  line_follow_ctrl #(.NSENS(3), .MIN_SPIN(MS), .LOST_TO(LT)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .induct(induct), .proxim(proxim), .red(red),
    .motor_in(motor_in_a), .motor_en(motor_en_a), .state(state_a), .fault(fault_a),
    .jct_cnt(jct_a));

  line_follow_ctrl #(.NSENS(5), .MIN_SPIN(MS), .LOST_TO(LT)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .induct(induct5), .proxim(proxim), .red(red),
    .motor_in(motor_in_b), .motor_en(motor_en_b), .state(state_b), .fault(fault_b),
    .jct_cnt(jct_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_a(input logic [2:0] exp, input int budget);
    int n;
    n = 0;
    while (state_a !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic duty_cnt(input bit sel_b, output int ones);
    ones = 0;
    repeat (256) begin
      @(negedge clk);
      if ((sel_b ? motor_en_b : motor_en_a) == 2'b11) ones++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    negs(2);
    check("rst_state", state_a, 0);
    check("rst_motor_in", motor_in_a, 0);
    check("rst_motor_en", motor_en_a, 0);
    check("rst_fault", fault_a, 0);
    check("rst_jct", jct_a, 0);

    rst_n = 1'b1;
    run   = 1'b1;
    negs(1); check("rdy_hold1", state_a, 0);
    negs(1); check("rdy_hold2", state_a, 0);
    negs(1); check("idle_exit", state_a, 1);
    negs(8);
    check("fwd_state", state_a, 1);
    check("fwd_cmd", motor_in_a, 4'b1001);
    duty_cnt(1'b0, n); check("duty_fwd", n, 200);

    induct = 3'b011;
    negs(3); check("lat_hold", motor_in_a, 4'b1001);
    negs(1); check("lat_left", motor_in_a, 4'b0101);
    induct = 3'b110;
    negs(4); check("right_cmd", motor_in_a, 4'b1010);
    duty_cnt(1'b0, n); check("duty_turn", n, 140);
    induct = 3'b101;
    negs(4); check("fwd_again", motor_in_a, 4'b1001);

    // First junction turns right, centre returns at once
    induct = 3'b000;
    negs(4);
    check("junc_state", state_a, 2);
    check("junc_right", motor_in_a, 4'b1010);
    induct = 3'b101;
    n = 0;
    while (state_a == 3'd2 && n < 200) begin
      n++;
      negs(1);
    end
    check("junc_len", n, MS);
    check("junc_exit", state_a, 1);
    check("junc_exit_cmd", motor_in_a, 4'b1001);

    red = 1'b1; negs(4); red = 1'b0; negs(4);
    check("red_cnt1", jct_a, 1);
    check("red_no_spin", state_a, 1);
    induct = 3'b000;
    negs(4);
    check("junc2_state", state_a, 2);
    check("junc2_left", motor_in_a, 4'b0101);
    negs(MS + 10); check("junc_hold_jct", state_a, 2);
    induct = 3'b101;
    wait_a(3'd1, 60); check("junc2_exit", state_a, 1);

    proxim = 1'b1; negs(4); proxim = 1'b0;
    check("cone_spin1", state_a, 3);
    check("spin_cmd", motor_in_a, 4'b1010);
    wait_a(3'd1, 100); check("spin1_exit", state_a, 1);
    red = 1'b1; negs(4);
    check("cone_spin2", state_a, 3);
    check("red_cnt2", jct_a, 2);
    wait_a(3'd1, 100); check("spin2_exit", state_a, 1);
    red = 1'b0; negs(4);
    red = 1'b1; negs(4);
    check("cone_clr", state_a, 1);
    check("red_cnt3", jct_a, 3);
    red = 1'b0; negs(4);

    induct = 3'b111;
    negs(4);
    check("lost_state", state_a, 4);
    check("lost_cmd", motor_in_a, 4'b1001);
    induct = 3'b101;
    negs(4); check("lost_recover", state_a, 1);

    induct = 3'b111;
    negs(4); check("lost2_state", state_a, 4);
    n = 0;
    while (state_a == 3'd4 && n < 200) begin
      n++;
      negs(1);
    end
    check("lost_len", n, LT);
    check("fault_state", state_a, 5);
    check("fault_flag", fault_a, 1);
    check("fault_en", motor_en_a, 0);
    check("fault_cmd", motor_in_a, 0);
    induct = 3'b101;
    negs(6); check("fault_sticky", state_a, 5);
    run = 1'b0;
    negs(1);
    check("run0_state", state_a, 0);
    check("run0_fault", fault_a, 0);
    check("run0_jct_kept", jct_a, 3);

    // Reset in the middle of a cone spin
    run = 1'b1;
    negs(4); check("rerun_state", state_a, 1);
    proxim = 1'b1; negs(4); proxim = 1'b0;
    check("spin3_state", state_a, 3);
    negs(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state_a, 0);
    check("arst_cmd", motor_in_a, 0);
    check("arst_en", motor_en_a, 0);
    check("arst_jct", jct_a, 0);
    check("arst_fault", fault_a, 0);
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    negs(6);
    check("post_rst_state", state_a, 0);
    check("post_rst_cmd", motor_in_a, 0);
    check("post_rst_en", motor_en_a, 0);

    run = 1'b1;
    negs(8);
    check("b_state", state_b, 1);
    check("b_fwd", motor_in_b, 4'b1001);
    duty_cnt(1'b1, n); check("b_duty_fwd", n, 200);
    induct5 = 5'b01111;
    negs(3); check("b_lat_hold", motor_in_b, 4'b1001);
    negs(1); check("b_lat_left", motor_in_b, 4'b0101);
    induct5 = 5'b11110;
    negs(4); check("b_right", motor_in_b, 4'b1010);

    repeat (255) begin
      red = 1'b1; negs(2);
      red = 1'b0; negs(2);
    end
    negs(4); check("jct_255", jct_a, 255);
    red = 1'b1; negs(2); red = 1'b0; negs(4);
    check("jct_wrap", jct_a, 0);
    check("wrap_state", state_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_follow_ctrl.md
LINE_FOLLOW_CTRL -- requirements
Module: line_follow_ctrl

Interface
REQ-001 SHALL have parameter NSENS, default 3, number of inductive sensors (odd, >=3); bit NSENS-1 leftmost, bit 0 rightmost.
REQ-002 SHALL have parameter PWM_W, default 8, PWM counter width.
REQ-003 SHALL have parameter DUTY_FWD, default 200, enable duty for forward drive (on-cycles per 2^PWM_W).
REQ-004 SHALL have parameter DUTY_TURN, default 140, enable duty for pivots and spins.
REQ-005 SHALL have parameter MIN_SPIN, default 1000, minimum cycles of any junction turn or 180 spin.
REQ-006 SHALL have parameter LOST_TO, default 5000, cycles without tape before fault.
REQ-007 SHALL have ports: clk in 1 system clock; rst_n in 1 async active-low reset; one clock, reset asynchronous active-low.
REQ-008 SHALL have ports: run in 1 enable; induct in NSENS sensors, active low (0 = on tape); proxim in 1 cone detect, active high; red in 1 junction marker, active high.
REQ-009 SHALL have ports: motor_in out 4 direction code; motor_en out 2 PWM enables {left,right}; state out 3 FSM state; fault out 1 sticky lost fault; jct_cnt out 8 red-marker count.

Function
REQ-010 SHALL synchronise induct, proxim, red through 2 flops; edges detected on synchronised values; all outputs registered.
REQ-011 SHALL use direction codes FWD=4'b1001, LEFT=4'b0101, RIGHT=4'b1010, HALT=4'b0000.
REQ-012 SHALL decode on=~induct_sync, C=(NSENS-1)/2: all on -> JCT pattern; none on -> NONE; count(on above C) > count(on below C) -> LEFT; less -> RIGHT; equal -> FWD.
REQ-013 SHALL use states IDLE=0, FOLLOW=1, JUNC=2, SPIN=3, LOST=4, FAULT=5.
REQ-014 IDLE: motor_in=HALT, motor_en=0; run=1 -> FOLLOW next cycle.
REQ-015 FOLLOW: motor_in = decoded LEFT/RIGHT/FWD, stored to last_cmd; JCT -> JUNC; NONE -> LOST.
REQ-016 JUNC: motor_in = dir_sel ? LEFT : RIGHT for >=MIN_SPIN cycles, then until on[C]=1 with JCT absent -> FOLLOW.
REQ-017 SPIN: motor_in=RIGHT for >=MIN_SPIN cycles, then until on[C]=1 -> FOLLOW.
REQ-018 LOST: motor_in=last_cmd; any on bit within LOST_TO cycles -> FOLLOW; counter reaching LOST_TO -> FAULT.
REQ-019 FAULT: motor_in=HALT, motor_en=0, fault=1; exits only via run=0 (-> IDLE, fault clears) or reset.
REQ-020 proxim rising edge in FOLLOW or JUNC -> SPIN, toggles cone_flag; ignored in SPIN, LOST, IDLE, FAULT.
REQ-021 red rising edge: jct_cnt+1 (wraps 255->0), dir_sel toggles; if cone_flag=1 and state FOLLOW/JUNC -> SPIN.
REQ-022 red falling edge clears cone_flag.
REQ-023 motor_en: free-running PWM_W counter; both bits = (cnt < duty), duty = DUTY_FWD when motor_in=FWD, DUTY_TURN for LEFT/RIGHT, 0 in IDLE/FAULT.
REQ-024 SHALL apply per-cycle priority: run=0 > lost timeout > proxim edge > red edge > pattern decode.
REQ-025 run=0 in any state -> IDLE next cycle; spin/lost counters clear; jct_cnt, dir_sel, cone_flag retained.
REQ-026 latency: induct change visible on motor_in 3 cycles after first sampling edge.
REQ-027 spin/lost counters SHALL saturate, never wrap; both clear on every state entry.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, motor_in=HALT, motor_en=0, fault=0, jct_cnt=0, dir_sel=0, cone_flag=0, last_cmd=FWD, sync flops and counters 0.
REQ-029 Reset deassertion SHALL be synchronised; first FSM transition no earlier than the second clk edge after rst_n rises.
REQ-030 Reset asserted mid-SPIN or mid-JUNC SHALL abandon the turn with no residual motion on release.

Verification
REQ-031 run=1, induct=3'b101 steady -> motor_in=1001, motor_en duty 200/256, state=1.
REQ-032 induct 3'b101 -> 3'b011 -> motor_in=0101 exactly 3 cycles later; 3'b110 -> 1010.
REQ-033 induct=3'b000 with dir_sel=0 -> state=2, motor_in=1010 >=MIN_SPIN cycles; red pulse then next junction -> 0101, jct_cnt=1.
REQ-034 proxim pulse in FOLLOW, then red rising -> SPIN entered twice, motor_in=1010; red falling clears cone_flag.
REQ-035 induct=3'b111 held LOST_TO cycles -> fault=1, motor_en=0; run=0 -> state=0, fault=0.
REQ-036 rst_n low mid-SPIN -> all outputs reset values same cycle; NSENS=5 run repeats REQ-031/032 with 5'b11011/5'b01111.
